// File: rtl/texture_column_sequencer_if.sv
// texture_column_sequencer_if: descriptor, textures and frame-buffer signals of the column sequencer.
// master = sequencer side, slave = environment side (DDA FIFO, textures block, frame buffer).
interface texture_column_sequencer_if;
   logic        ray_valid_in;
   logic        ray_ready_out;
   logic [8:0]  hcount_ray_in;
   logic [7:0]  lineheight_in;
   logic [9:0]  drawstart_in;
   logic [15:0] wallX_in;
   logic [3:0]  texture_in;
   logic        tex_req_out;
   logic [15:0] tex_wallX_out;
   logic [7:0]  tex_lineheight_out;
   logic [9:0]  tex_drawstart_out;
   logic [7:0]  tex_vcount_out;
   logic [3:0]  tex_texture_out;
   logic [15:0] tex_pixel_in;
   logic        tex_valid_in;
   logic        fb_we_out;
   logic [15:0] fb_addr_out;
   logic [15:0] fb_data_out;
   logic        col_done_out;
   logic        tex_err_out;
   modport master (
      input  ray_valid_in, hcount_ray_in, lineheight_in, drawstart_in, wallX_in, texture_in,
             tex_pixel_in, tex_valid_in,
      output ray_ready_out, tex_req_out, tex_wallX_out, tex_lineheight_out, tex_drawstart_out,
             tex_vcount_out, tex_texture_out, fb_we_out, fb_addr_out, fb_data_out, col_done_out,
             tex_err_out
   );
   modport slave (
      output ray_valid_in, hcount_ray_in, lineheight_in, drawstart_in, wallX_in, texture_in,
             tex_pixel_in, tex_valid_in,
      input  ray_ready_out, tex_req_out, tex_wallX_out, tex_lineheight_out, tex_drawstart_out,
             tex_vcount_out, tex_texture_out, fb_we_out, fb_addr_out, fb_data_out, col_done_out,
             tex_err_out
   );
endinterface

// File: rtl/texture_column_sequencer.sv
// texture_column_sequencer: walks rows 0..SCREEN_HEIGHT-1 of one ray column, fetching texels for
// wall rows from the textures block and writing every pixel to the frame buffer.
// Ports: pixel_clk_in (clock), rst_n_in (async active-low reset), bus (master modport):
//   ray_*      descriptor handshake from the DDA FIFO
//   tex_*      level request / latched fields to textures, texel + valid pulse back
//   fb_*       registered frame-buffer write port (addr = vcount*SCREEN_WIDTH + hcount)
//   col_done_out one-cycle pulse after the column, tex_err_out sticky timeout flag
// Option: define FLOOR_CEIL_FILL_EN to write ceiling/floor colours on non-wall rows;
// when undefined those rows are skipped (still one cycle each) and only wall rows write.
module texture_column_sequencer #(
   parameter int          SCREEN_WIDTH   = 320,
   parameter int          SCREEN_HEIGHT  = 180,
   parameter int          TIMEOUT_CYCLES = 64,
   parameter logic [15:0] CEIL_COLOR     = 16'h0000,
   parameter logic [15:0] FLOOR_COLOR    = 16'h4208,
   parameter logic [15:0] ERROR_COLOR    = 16'hF81F
) (
   input logic pixel_clk_in,
   input logic rst_n_in,
   texture_column_sequencer_if.master bus
);
   localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
   typedef enum logic [2:0] {IDLE, ROW, REQ, GAP, DONE} state_t;
   state_t      r_state;
   logic        r_ready, r_req, r_we, r_done, r_err;
   logic [8:0]  r_hcount;
   logic [7:0]  r_lineheight, r_vcount;
   logic [9:0]  r_drawstart;
   logic [15:0] r_wallx, r_addr, r_data;
   logic [3:0]  r_texture;
   logic [CW-1:0] r_cnt;
   logic [10:0] w_end_raw, w_end;
   logic        w_empty, w_wall, w_last, w_timeout;
   logic [15:0] w_addr;
   // Span end is clipped to the screen; empty spans never request so textures never divides by 0.
   assign w_end_raw = 11'(r_drawstart) + 11'(r_lineheight) - 11'd1;
   assign w_end     = (w_end_raw > 11'(SCREEN_HEIGHT - 1)) ? 11'(SCREEN_HEIGHT - 1) : w_end_raw;
   assign w_empty   = (r_lineheight == 8'd0) || (r_drawstart >= 10'(SCREEN_HEIGHT));
   assign w_wall    = !w_empty && (10'(r_vcount) >= r_drawstart) && (11'(r_vcount) <= w_end);
   assign w_last    = r_vcount == 8'(SCREEN_HEIGHT - 1);
   assign w_timeout = r_cnt == CW'(TIMEOUT_CYCLES - 1);
   assign w_addr    = 16'(r_vcount) * 16'(SCREEN_WIDTH) + 16'(r_hcount);
   always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_state      <= IDLE;
         r_ready      <= 1'b0;
         r_req        <= 1'b0;
         r_we         <= 1'b0;
         r_done       <= 1'b0;
         r_err        <= 1'b0;
         r_hcount     <= '0;
         r_lineheight <= '0;
         r_drawstart  <= '0;
         r_wallx      <= '0;
         r_texture    <= '0;
         r_vcount     <= '0;
         r_addr       <= '0;
         r_data       <= '0;
         r_cnt        <= '0;
      end else begin
         r_we   <= 1'b0;
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               r_ready <= 1'b1;
               if (bus.ray_valid_in && r_ready) begin
                  r_hcount     <= bus.hcount_ray_in;
                  r_lineheight <= bus.lineheight_in;
                  r_drawstart  <= bus.drawstart_in;
                  r_wallx      <= bus.wallX_in;
                  r_texture    <= bus.texture_in;
                  r_vcount     <= '0;
                  r_ready      <= 1'b0;
                  r_state      <= ROW;
               end
            end
            ROW: begin
               if (w_wall) begin
                  r_req   <= 1'b1;
                  r_cnt   <= '0;
                  r_state <= REQ;
               end else begin
`ifdef FLOOR_CEIL_FILL_EN
                  r_we   <= 1'b1;
                  r_addr <= w_addr;
                  r_data <= (10'(r_vcount) < r_drawstart) ? CEIL_COLOR : FLOOR_COLOR;
`endif
                  r_state  <= w_last ? DONE : ROW;
                  r_vcount <= w_last ? r_vcount : r_vcount + 8'd1;
               end
            end
            REQ: begin
               r_cnt <= r_cnt + CW'(1);
               if (bus.tex_valid_in || w_timeout) begin
                  r_we    <= 1'b1;
                  r_addr  <= w_addr;
                  r_data  <= bus.tex_valid_in ? bus.tex_pixel_in : ERROR_COLOR;
                  r_err   <= r_err | !bus.tex_valid_in;
                  r_req   <= 1'b0;
                  r_state <= GAP;
               end
            end
            GAP: begin
               r_state  <= w_last ? DONE : ROW;
               r_vcount <= w_last ? r_vcount : r_vcount + 8'd1;
            end
            DONE: begin
               r_done  <= 1'b1;
               r_ready <= 1'b1;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
   assign bus.ray_ready_out      = r_ready;
   assign bus.tex_req_out        = r_req;
   assign bus.tex_wallX_out      = r_wallx;
   assign bus.tex_lineheight_out = r_lineheight;
   assign bus.tex_drawstart_out  = r_drawstart;
   assign bus.tex_vcount_out     = r_vcount;
   assign bus.tex_texture_out    = r_texture;
   assign bus.fb_we_out          = r_we;
   assign bus.fb_addr_out        = r_addr;
   assign bus.fb_data_out        = r_data;
   assign bus.col_done_out       = r_done;
   assign bus.tex_err_out        = r_err;
endmodule

// File: tb/tb_texture_column_sequencer.sv
// tb_texture_column_sequencer: directed + randomized columns against a row-by-row reference model.
module tb_texture_column_sequencer;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   texture_column_sequencer_if bus();
   texture_column_sequencer dut (.pixel_clk_in(clk), .rst_n_in(rst_n), .bus(bus));
   always #5 clk = ~clk;

   int checks = 0, failures = 0;
   int lat_mode = 19, lat_sum = 0, req_rises = 0, cur_lat = 0, tcnt = 0;
   bit armed = 0, prev_req = 0, prev_ready = 0, in_col = 0;
   int stab_err = 0, busy_ready = 0, done_pulses = 0, wr_total = 0, cols = 0;
   logic [3:0]  exp_tex = '0;
   logic [15:0] exp_wx = '0;
   logic [9:0]  exp_ds = '0;
   logic [7:0]  exp_lh = '0;
   logic [15:0] wa[$], wd[$];

   function automatic logic [15:0] texel(logic [3:0] t, logic [15:0] wx, logic [9:0] ds,
                                         logic [7:0] lh, logic [7:0] v);
      return wx ^ {t, v, 4'h0} ^ {6'h0, ds} ^ {lh, 8'h0};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // textures block model: answers cur_lat cycles after each rising request (0 = never),
   // and toggles junk valid pulses while no request is pending.
   initial begin
      bus.tex_valid_in = 1'b0;
      bus.tex_pixel_in = '0;
   end
   always @(negedge clk) begin
      if (bus.tex_req_out && !prev_req && !armed) begin
         armed = 1;
         tcnt = 0;
         cur_lat = lat_mode < 0 ? int'($urandom_range(1, 8)) : lat_mode;
         lat_sum += (cur_lat == 0) ? 64 : cur_lat;
         req_rises++;
      end
      if (armed && bus.tex_req_out) begin
         tcnt++;
         bus.tex_valid_in = (cur_lat != 0) && (tcnt == cur_lat);
         bus.tex_pixel_in = bus.tex_valid_in ? texel(bus.tex_texture_out, bus.tex_wallX_out,
            bus.tex_drawstart_out, bus.tex_lineheight_out, bus.tex_vcount_out) : 16'(
$urandom);
      end else begin
         armed = 0;
         bus.tex_valid_in = ($urandom_range(0, 3) == 0);
         bus.tex_pixel_in = 16'hDEAD;
      end
      prev_req = bus.tex_req_out;
   end

   // monitor: collects writes, checks fixed fields and ready while a column is in flight
   always @(negedge clk) begin
      if (!rst_n) in_col = 0;
      else begin
         if (bus.col_done_out) begin
            in_col = 0;
            done_pulses++;
         end
         if (prev_ready && !bus.ray_ready_out) in_col = 1;
         if (in_col) begin
            if (bus.ray_ready_out) busy_ready++;
            if (bus.tex_texture_out !== exp_tex || bus.tex_wallX_out !== exp_wx ||
                bus.tex_drawstart_out !== exp_ds || bus.tex_lineheight_out !== exp_lh) stab_err++;
         end
      end
      prev_ready = bus.ray_ready_out;
      if (bus.fb_we_out) begin
         wa.push_back(bus.fb_addr_out);
         wd.push_back(bus.fb_data_out);
         wr_total++;
      end
   end

   task automatic run_column(input string tag, input logic [8:0] h, input logic [9:0] ds,
                             input logic [7:0] lh, input logic [3:0] tx, input logic [15:0] wx,
                             input int lm, input bit keep);
      logic [15:0] ea[$], ed[$];
      int walls = 0, nonwall = 0, n = 0, hi;
      bit wall;
      exp_tex = tx; exp_wx = wx; exp_ds = ds; exp_lh = lh;
      lat_mode = lm; lat_sum = 0; req_rises = 0; stab_err = 0; busy_ready = 0;
      wa.delete(); wd.delete();
      hi = int'(ds) + int'(lh) - 1;
      if (hi > 179) hi = 179;
      for (int v = 0; v < 180; v++) begin
         wall = lh != 0 && ds < 180 && v >= int'(ds) && v <= hi;
         if (wall) begin
            walls++;
            ea.push_back(16'(v * 320 + int'(h)));
            ed.push_back(lm == 0 ? 16'hF81F : texel(tx, wx, ds, lh, 8'(v)));
         end else begin
            nonwall++;
`ifdef FLOOR_CEIL_FILL_EN
            ea.push_back(16'(v * 320 + int'(h)));
            ed.push_back(v < int'(ds) ? 16'h0000 : 16'h4208);
`endif
         end
      end
      bus.hcount_ray_in = h; bus.drawstart_in = ds; bus.lineheight_in = lh;
      bus.texture_in = tx; bus.wallX_in = wx; bus.ray_valid_in = 1'b1;
      while (!bus.ray_ready_out && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_accept"}, 32'(bus.ray_ready_out), 1);
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (n == 1 && !keep) bus.ray_valid_in = 1'b0;
      end while (!bus.col_done_out && n < 30000);
      cols++;
      check({tag, "_done"}, 32'(bus.col_done_out), 1);
      check({tag, "_cycles"}, n, nonwall + 2 * walls + lat_sum + 2);
      check({tag, "_req_rises"}, req_rises, walls);
      check({tag, "_nwrites"}, wa.size(), ea.size());
      for (int i = 0; i < wa.size() && i < ea.size(); i++) begin
         check($sformatf("%s_addr%0d", tag, i), wa[i], ea[i]);
         check($sformatf("%s_data%0d", tag, i), wd[i], ed[i]);
      end
      check({tag, "_fields_stable"}, stab_err, 0);
      check({tag, "_ready_busy"}, busy_ready, 0);
   endtask

   initial begin
      int wb, db;
      logic [3:0] t;
      bus.ray_valid_in = 1'b0;
      bus.hcount_ray_in = '0; bus.lineheight_in = '0; bus.drawstart_in = '0;
      bus.wallX_in = '0; bus.texture_in = '0;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_ready", 32'(bus.ray_ready_out), 0);
      check("rst_req", 32'(bus.tex_req_out), 0);
      check("rst_we", 32'(bus.fb_we_out), 0);
      check("rst_done", 32'(bus.col_done_out), 0);
      check("rst_err", 32'(bus.tex_err_out), 0);
      check("rst_fields", {bus.tex_texture_out, bus.tex_vcount_out, bus.tex_drawstart_out}, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_rst", 32'(bus.ray_ready_out), 1);

      run_column("normal", 9'd5, 10'd80, 8'd20, 4'd3, 16'(
$urandom), 19, 0);
      run_column("empty", 9'd7, 10'd50, 8'd0, 4'd1, 16'h1234, 19, 0);
      run_column("clip", 9'd319, 10'd170, 8'd40, 4'd9, 16'(
$urandom), -1, 0);
      check("clip_last_addr", wa.size() > 0 ? wa[wa.size()-1] : 0, 57599);
      check("err_before_timeout", 32'(bus.tex_err_out), 0);
      run_column("timeout", 9'd100, 10'd0, 8'd1, 4'd2, 16'h00FF, 0, 0);
      check("err_after_timeout", 32'(bus.tex_err_out), 1);

      t = 4'(
$urandom);
      run_column("b2b_a", 9'd20, 10'd60, 8'd30, t, 16'h5A5A, -1, 1);
      check("b2b_ready_at_done", 32'(bus.ray_ready_out), 1);
      run_column("b2b_b", 9'd21, 10'd10, 8'd100, t ^ 4'h5, 16'hA5A5, -1, 0);
      check("err_sticky", 32'(bus.tex_err_out), 1);

      for (int k = 0; k < 5; k++)
         run_column($sformatf("rand%0d", k), 9'($urandom_range(0, 319)),
                    10'($urandom_range(0, 200)), 8'($urandom_range(0, 255)), 4'(
$urandom),
                    16'(
$urandom), -1, 0);

      // abandon a column while a request is outstanding
      lat_mode = 19;
      bus.hcount_ray_in = 9'd33; bus.drawstart_in = 10'd0; bus.lineheight_in = 8'd50;
      bus.texture_in = 4'd6; bus.wallX_in = 16'h0F0F;
      exp_tex = 4'd6; exp_wx = 16'h0F0F; exp_ds = 10'd0; exp_lh = 8'd50;
      bus.ray_valid_in = 1'b1;
      wb = 0;
      while (!bus.tex_req_out && wb < 1000) begin
         @(negedge clk);
         wb++;
         if (!bus.ray_ready_out) bus.ray_valid_in = 1'b0;
      end
      check("midrst_req_seen", 32'(bus.tex_req_out), 1);
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_req", 32'(bus.tex_req_out), 0);
      check("midrst_we", 32'(bus.fb_we_out), 0);
      check("midrst_ready", 32'(bus.ray_ready_out), 0);
      check("midrst_err", 32'(bus.tex_err_out), 0);
      bus.ray_valid_in = 1'b0;
      wb = wr_total;
      db = done_pulses;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("midrst_ready_after", 32'(bus.ray_ready_out), 1);
      repeat (20) @(negedge clk);
      check("midrst_no_write", wr_total, wb);
      check("midrst_no_done", done_pulses, db);

      run_column("after_rst", 9'd1, 10'd90, 8'd5, 4'd12, 16'hBEEF, -1, 0);
      repeat (5) @(negedge clk);
      check("done_pulse_total", done_pulses, cols);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
